acc_mode_reg: RTL and testbench

Parametrised accumulator register for the accumulator datapath. It generalises the n-bit load/store register with preset and clear. It adds an opcode-driven command set: load, increment, decrement, clear, and multi-cycle shift/rotate by a programmable amount. A start/busy/done handshake lets the control FSM sequence it, and zero/carry flags feed the status logic.

---
 rtl/acc_mode_reg.sv | 182 ++++++++++++++++++
 tb/tb_acc_mode_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/acc_mode_reg.sv
// Accumulator register: load/inc/dec/clear plus multi-cycle shift/rotate with start/busy/done handshake.
// Latency: single-cycle ops update out on the accepting edge (done next cycle); shifts take k=min(amt,WIDTH) cycles.
// Backpressure: start is accepted only while busy=0; a start seen while busy is dropped entirely.
module acc_mode_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [AW-1:0]    W_AW  = AW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    // Architectural state
    state_e           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_done;
    logic [AW-1:0]    r_cnt;
    op_e              r_sop;

    // Next-state values from the combinational process
    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_carry_nxt;
    logic             w_done_nxt;
    logic [AW-1:0]    w_cnt_nxt;
    op_e              w_sop_nxt;

    // Helpers
    op_e              w_op;
    logic [AW-1:0]    w_k;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_carry;

    assign w_op  = op_e'(op);
    // Shift counts beyond the register width behave as a full-width shift.
    assign w_k   = (amt > W_AW) ? W_AW : amt;
    assign w_inc = {1'b0, r_out} + {1'b0, ONE_W};
    assign w_dec = r_out - ONE_W;

    // One 1-bit step of the latched shift/rotate, with the bit that leaves the register
    always_comb begin
        w_step_out   = r_out;
        w_step_carry = r_carry;
        case (r_sop)
            OP_SHL: begin
                w_step_out   = {r_out[WIDTH-2:0], 1'b0};
                w_step_carry = r_out[WIDTH-1];
            end
            OP_SHR: begin
                w_step_out   = {1'b0, r_out[WIDTH-1:1]};
                w_step_carry = r_out[0];
            end
            OP_ROL: begin
                w_step_out   = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                w_step_carry = r_out[WIDTH-1];
            end
            default: begin
                w_step_out   = r_out;
                w_step_carry = r_carry;
            end
        endcase
    end

    // Next-state and datapath decisions: running shift step first, else an accepted start
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_carry_nxt = r_carry;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_sop_nxt   = r_sop;

        if (r_state == ST_SHIFT) begin
            w_out_nxt   = w_step_out;
            w_carry_nxt = w_step_carry;
            w_cnt_nxt   = r_cnt - AW'(1);
            if (r_cnt == AW'(1)) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end else if (start) begin
            w_done_nxt = 1'b1;
            case (w_op)
                OP_NOP: begin
                    w_out_nxt = r_out;
                end
                OP_LOAD: begin
                    w_out_nxt   = in;
                    w_carry_nxt = 1'b0;
                end
                OP_INC: begin
                    w_out_nxt   = w_inc[WIDTH-1:0];
                    w_carry_nxt = w_inc[WIDTH];
                end
                OP_DEC: begin
                    w_out_nxt   = w_dec;
                    w_carry_nxt = (r_out == '0);
                end
                OP_CLR: begin
                    w_out_nxt   = '0;
                    w_carry_nxt = 1'b0;
                end
                default: begin
                    // SHL / SHR / ROL: a zero count completes immediately with no movement.
                    if (w_k == '0) begin
                        w_carry_nxt = 1'b0;
                    end else begin
                        w_done_nxt  = 1'b0;
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = w_k;
                        w_sop_nxt   = w_op;
                    end
                end
            endcase
        end
    end

    // State register: clr beats set, both abort any shift without a done pulse
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_out   <= RESET_VAL;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_sop   <= OP_NOP;
        end else if (!set) begin
            r_state <= ST_IDLE;
            r_out   <= '1;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_sop   <= OP_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_carry <= w_carry_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sop   <= w_sop_nxt;
        end
    end

    assign out   = r_out;
    assign busy  = (r_state == ST_SHIFT);
    assign done  = r_done;
    assign carry = r_carry;
    assign zero  = (r_out == '0);

endmodule

// File: tb/tb_acc_mode_reg.sv
// Bench for acc_mode_reg (WIDTH=8): directed plan steps then random traffic against a reference model.
// Latency: model updated at each rising edge, outputs compared 1 time unit later.
// Backpressure: model drops starts while busy, mirroring the accept rule.
module tb_acc_mode_reg;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH) + 1;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clr, set, start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_d;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] out;
    logic             busy, done, zero, carry;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_out = 0, m_carry = 0, m_busy = 0, m_done = 0;
    int m_base = 0, m_op = 0, m_k = 0, m_j = 0;

    acc_mode_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .clk(clk), .clr(clr), .set(set), .start(start), .op(op),
        .in(in_d), .amt(amt), .out(out), .busy(busy), .done(done),
        .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result after j single-bit steps of a shift/rotate applied to v, in closed form.
    task automatic shifted(input int sop, input int v, input int j, output int r, output int c);
        case (sop)
            4: begin r = (v << j) & MASK;                        c = (v >> (WIDTH - j)) & 1; end
            5: begin r = v >> j;                                 c = (v >> (j - 1)) & 1;     end
            default: begin r = ((v << j) | (v >> (WIDTH - j))) & MASK; c = (v >> (WIDTH - j)) & 1; end
        endcase
    endtask

    task automatic model_edge();
        int k;
        if (!clr) begin
            m_out = 0; m_carry = 0; m_busy = 0; m_done = 0;
        end else if (!set) begin
            m_out = MASK; m_carry = 0; m_busy = 0; m_done = 0;
        end else if (m_busy != 0) begin
            m_j++;
            shifted(m_op, m_base, m_j, m_out, m_carry);
            m_done = (m_j == m_k) ? 1 : 0;
            m_busy = (m_j == m_k) ? 0 : 1;
        end else begin
            m_done = 0;
            if (start) begin
                k = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
                m_done = 1;
                case (int'(op))
                    1: begin m_out = int'(in_d); m_carry = 0; end
                    2: begin m_carry = (m_out == MASK); m_out = (m_out + 1) % (MASK + 1); end
                    3: begin m_carry = (m_out == 0); m_out = (m_out + MASK) % (MASK + 1); end
                    7: begin m_out = 0; m_carry = 0; end
                    4, 5, 6: begin
                        if (k == 0) m_carry = 0;
                        else begin
                            m_done = 0; m_busy = 1;
                            m_base = m_out; m_op = int'(op); m_k = k; m_j = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic drive(input bit c, input bit s, input bit st, input int o, input int d, input int a);
        clr = c; set = s; start = st;
        op = 3'(o); in_d = 8'(d); amt = 4'(a);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".out"},   32'(out),   32'(m_out));
        check({tag, ".busy"},  32'(busy),  32'(m_busy));
        check({tag, ".done"},  32'(done),  32'(m_done));
        check({tag, ".carry"}, 32'(carry), 32'(m_carry));
        check({tag, ".zero"},  32'(zero),  32'(m_out == 0));
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);

        // 1. reset wins over a LOAD on the same edge
        drive(0, 1, 1, 1, 'h5A, 0); tick("rst");
        check("rst_out_lit", 32'(out), 32'h00);
        check("rst_zero_lit", 32'(zero), 32'd1);

        // 2. LOAD FF, INC wraps, DEC wraps
        drive(1, 1, 1, 1, 'hFF, 0); tick("ld_ff");
        drive(1, 1, 1, 2, 0, 0);    tick("inc");
        check("inc_out_lit", 32'(out), 32'h00);
        check("inc_carry_lit", 32'(carry), 32'd1);
        drive(1, 1, 1, 3, 0, 0);    tick("dec");
        check("dec_out_lit", 32'(out), 32'hFF);
        check("dec_carry_lit", 32'(carry), 32'd1);
        drive(1, 1, 0, 0, 0, 0);    tick("dec_done");

        // 3. SHL by 3 from 0x81
        drive(1, 1, 1, 1, 'h81, 0); tick("ld_81");
        drive(1, 1, 1, 4, 0, 3);    tick("shl_t0");
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("shl_step");
        check("shl_out_lit", 32'(out), 32'h08);
        check("shl_done_lit", 32'(done), 32'd1);
        tick("shl_after");

        // 4. SHR clamped to 8, with an ignored LOAD mid-shift
        drive(1, 1, 1, 1, 'hF0, 0); tick("ld_f0");
        drive(1, 1, 1, 5, 0, 12);   tick("shr_t0");
        drive(1, 1, 0, 0, 0, 0);    tick("shr_s1");
        drive(1, 1, 1, 1, 'h33, 0); tick("shr_s2");
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick("shr_step");
        check("shr_out_lit", 32'(out), 32'h00);
        check("shr_carry_lit", 32'(carry), 32'd1);
        tick("shr_after");

        // 5. ROL by 1, then zero-count SHL
        drive(1, 1, 1, 1, 'h81, 0); tick("ld_81b");
        drive(1, 1, 1, 6, 0, 1);    tick("rol_t0");
        drive(1, 1, 0, 0, 0, 0);    tick("rol_s1");
        check("rol_out_lit", 32'(out), 32'h03);
        check("rol_carry_lit", 32'(carry), 32'd1);
        drive(1, 1, 1, 4, 0, 0);    tick("shl0");
        check("shl0_busy_lit", 32'(busy), 32'd0);
        check("shl0_done_lit", 32'(done), 32'd1);
        check("shl0_carry_lit", 32'(carry), 32'd0);
        drive(1, 1, 0, 0, 0, 0);    tick("shl0_after");

        // 6. preset aborts a shift; clr beats set
        drive(1, 1, 1, 4, 0, 5);    tick("abort_t0");
        drive(1, 1, 0, 0, 0, 0);    tick("abort_s1");
        drive(1, 0, 0, 0, 0, 0);    tick("abort_set");
        check("set_out_lit", 32'(out), 32'hFF);
        check("set_busy_lit", 32'(busy), 32'd0);
        drive(1, 1, 0, 0, 0, 0);    tick("abort_nodone");
        drive(0, 0, 0, 0, 0, 0);    tick("clr_set");
        check("clrset_out_lit", 32'(out), 32'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 39) != 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
